// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry constants and FSM state type shared by the write-through data cache
package dcache_pkg;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_SETS       = 64;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W  = 2;
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - OFF_W;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESUME} dcache_state_t;
endpackage

// File: rtl/dcache_wt_if.sv
// dcache_wt_if: backing-memory bus between the data cache (master) and data memory (slave)
interface dcache_wt_if;
  import dcache_pkg::*;
  logic                  MemReq_o;
  logic                  MemWe_o;
  logic [ADDR_WIDTH-1:0] MemAddr_o;
  logic [DATA_WIDTH-1:0] MemWData_o;
  logic                  MemReady_i;
  logic                  MemRValid_i;
  logic [DATA_WIDTH-1:0] MemRData_i;
  modport master (output MemReq_o, MemWe_o, MemAddr_o, MemWData_o,
                  input  MemReady_i, MemRValid_i, MemRData_i);
  modport slave  (input  MemReq_o, MemWe_o, MemAddr_o, MemWData_o,
                  output MemReady_i, MemRValid_i, MemRData_i);
endinterface

// File: rtl/dcache_tag_store.sv
// dcache_tag_store: per-set valid bit and tag with a lookup port and a set/clear write port
module dcache_tag_store
  import dcache_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  input  logic             we_i,
  input  logic             wvalid_i,
  input  logic [IDX_W-1:0] w_idx_i,
  input  logic [TAG_W-1:0] w_tag_i
);
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];
  // valid bits clear asynchronously so a partial refill never survives reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else if (we_i) valid_q[w_idx_i] <= wvalid_i;
  end
  // tags only matter once their valid bit is set, so they need no reset
  always_ff @(posedge clk_i) begin
    if (we_i && wvalid_i) tag_q[w_idx_i] <= w_tag_i;
  end
  assign hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through read-allocate data cache; DCACHE_PERF_EN adds load/miss counters
module dcache_wt
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  RdEn_i,
  input  logic                  WrEn_i,
  input  logic [ADDR_WIDTH-1:0] Addr_i,
  input  logic [DATA_WIDTH-1:0] WData_i,
  output logic [DATA_WIDTH-1:0] RData_o,
  output logic                  Stall_o,
  dcache_wt_if.master           mem,
  output logic [31:0]           ReadCount_o,
  output logic [31:0]           MissCount_o
);
  dcache_state_t state_q, state_d;
  logic [WORD_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   data_q [NUM_SETS*WORDS_PER_LINE];
  logic                    hit, stall, da_we, tw_en, tw_valid;
  logic [IDX_W+WORD_W-1:0] da_ix;
  logic [DATA_WIDTH-1:0]   da_wd;
  logic [IDX_W-1:0]        tw_idx;
  logic [TAG_W-1:0]        a_tag, l_tag;
  logic [IDX_W-1:0]        a_idx, l_idx;
  logic [WORD_W-1:0]       a_word;
  assign a_tag  = Addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign a_idx  = Addr_i[OFF_W+WORD_W +: IDX_W];
  assign a_word = Addr_i[OFF_W +: WORD_W];
  assign l_tag  = addr_q[ADDR_WIDTH-3 -: TAG_W];
  assign l_idx  = addr_q[WORD_W +: IDX_W];
  assign Stall_o = stall & rst_ni;
  dcache_tag_store u_tags (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .lk_idx_i (a_idx),
    .lk_tag_i (a_tag),
    .hit_o    (hit),
    .we_i     (tw_en),
    .wvalid_i (tw_valid),
    .w_idx_i  (tw_idx),
    .w_tag_i  (l_tag)
  );
  // next state, memory bus, lookup result and array write controls
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdat_d         = wdat_q;
    stall          = 1'b0;
    RData_o        = '0;
    mem.MemReq_o   = 1'b0;
    mem.MemWe_o    = 1'b0;
    mem.MemAddr_o  = '0;
    mem.MemWData_o = '0;
    da_we          = 1'b0;
    da_ix          = {a_idx, a_word};
    da_wd          = WData_i;
    tw_en          = 1'b0;
    tw_valid       = 1'b0;
    tw_idx         = a_idx;
    unique case (state_q)
      IDLE: begin
        if (WrEn_i) begin
          stall   = 1'b1;
          da_we   = hit;
          addr_d  = Addr_i[ADDR_WIDTH-1:OFF_W];
          wdat_d  = WData_i;
          state_d = WR_REQ;
        end else if (RdEn_i) begin
          RData_o = hit ? data_q[{a_idx, a_word}] : '0;
          stall   = !hit;
          tw_en   = !hit;
          addr_d  = hit ? addr_q : Addr_i[ADDR_WIDTH-1:OFF_W];
          cnt_d   = hit ? cnt_q : '0;
          state_d = hit ? IDLE : RD_REQ;
        end
      end
      RD_REQ: begin
        stall         = 1'b1;
        mem.MemReq_o  = 1'b1;
        mem.MemAddr_o = {addr_q[ADDR_WIDTH-3:WORD_W], cnt_q, 2'b00};
        state_d       = mem.MemReady_i ? RD_WAIT : RD_REQ;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem.MemRValid_i) begin
          da_we = 1'b1;
          da_ix = {l_idx, cnt_q};
          da_wd = mem.MemRData_i;
          if (cnt_q == WORD_W'(WORDS_PER_LINE-1)) begin
            tw_en    = 1'b1;
            tw_valid = 1'b1;
            tw_idx   = l_idx;
            state_d  = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        stall          = 1'b1;
        mem.MemReq_o   = 1'b1;
        mem.MemWe_o    = 1'b1;
        mem.MemAddr_o  = {addr_q, 2'b00};
        mem.MemWData_o = wdat_q;
        state_d        = mem.MemReady_i ? RESUME : WR_REQ;
      end
      RESUME: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // FSM state, refill word counter and access latches
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
    end
  end
  // data array: store hits and refill words
  always_ff @(posedge clk_i) begin
    if (da_we) data_q[da_ix] <= da_wd;
  end
`ifdef DCACHE_PERF_EN
  logic        rd_hit, rd_miss;
  logic [31:0] rd_cnt_q, miss_cnt_q;
  assign rd_hit  = (state_q == IDLE) && RdEn_i && !WrEn_i && hit;
  assign rd_miss = (state_q == IDLE) && RdEn_i && !WrEn_i && !hit;
  // saturating counts of retired loads and refills started
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (rd_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
  assign ReadCount_o = rd_cnt_q;
  assign MissCount_o = miss_cnt_q;
`else
  assign ReadCount_o = '0;
  assign MissCount_o = '0;
`endif
endmodule
